rx_payload_byte_packer_ble: RTL and testbench

//  Sits directly downstream of the BLE payload receiver chain. Collects the serial payload bit stream
//  (LSB first), packs it into bytes, buffers them in a small FIFO for the AHB-side reader, and reports

---
 rtl/rx_ble_pkg.sv | 11 +
 rtl/sync_fifo_ble.sv | 60 ++++++
 rtl/rx_payload_byte_packer_ble.sv | 134 +++++++++++++
 tb/tb_rx_payload_byte_packer_ble.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ble_pkg.sv
// Shared definitions for the BLE payload byte packer: FSM state encoding and byte geometry.
package rx_ble_pkg;

  localparam int BITS_PER_BYTE = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COLLECT  = 2'd1;
  localparam logic [1:0] ST_WAIT_CRC = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

endpackage

// File: rtl/sync_fifo_ble.sv
// Show-ahead synchronous FIFO: head byte is visible whenever the FIFO is non-empty.
// A push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module sync_fifo_ble
  import rx_ble_pkg::*;
#(
  parameter int AW = 4,
  parameter int W  = BITS_PER_BYTE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_rd_data,
  output logic          o_not_empty,
  output logic [AW:0]   o_count,
  output logic          o_drop
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0] r_mem [2**AW];
  logic [AW:0]  r_wr_cnt;
  logic [AW:0]  r_rd_cnt;
  logic [AW:0]  w_count;
  logic         w_empty;
  logic         w_full;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_count   = r_wr_cnt - r_rd_cnt;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == DEPTH);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_count     = w_count;
  assign o_not_empty = !w_empty;
  // Gate the head so the output reads 0 while nothing valid is held.
  assign o_rd_data   = w_empty ? '0 : r_mem[r_rd_cnt[AW-1:0]];
  assign o_drop      = i_push && w_full && !w_do_pop;

  // Pointer update: reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_do_push) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_do_pop)  r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && !i_flush && w_do_push) r_mem[r_wr_cnt[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/rx_payload_byte_packer_ble.sv
// Packs the LSB-first BLE payload bit stream into bytes, buffers them in a show-ahead FIFO and
// reports packet completion with sticky error/overflow status.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE     | waiting for start; bit_valid and error_strobe ignored
//  COLLECT  | shifting payload bits, pushing each completed byte
//  WAIT_CRC | all bits in, waiting for the final error_strobe
//  DONE     | one-cycle done pulse, then back to IDLE
module rx_payload_byte_packer_ble
  import rx_ble_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int NBITS_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NBITS_W-1:0] n_bits,
  input  logic               crc_enable,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               error_in,
  input  logic               error_strobe,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic [FIFO_AW:0]   fill_level,
  output logic               busy,
  output logic               done,
  output logic               rx_error,
  output logic               overflow
);

  localparam logic [NBITS_W-1:0] ONE  = {{(NBITS_W-1){1'b0}}, 1'b1};
  localparam logic [NBITS_W-1:0] ZERO = '0;

  logic [1:0]         r_state;
  logic [NBITS_W-1:0] r_bits_left;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_rx_error;
  logic               r_overflow;
  logic               r_crc_en_q;
  logic               r_strobe_seen;

  logic               w_bit_take;
  logic               w_last_bit;
  logic               w_byte_done;
  logic [7:0]         w_wr_data;
  logic               w_push;
  logic               w_flush;
  logic               w_strobe_take;
  logic               w_drop;

  assign w_bit_take    = (r_state == ST_COLLECT) && bit_valid && (r_bits_left != ZERO);
  assign w_last_bit    = w_bit_take && (r_bits_left == ONE);
  assign w_byte_done   = w_bit_take && ((r_bit_idx == 3'd7) || (r_bits_left == ONE));
  // Upper shift bits are always zero here, so a short final byte comes out zero-padded.
  assign w_wr_data     = r_shift | ({7'd0, bit_in} << r_bit_idx);
  // start takes priority over everything else in its cycle.
  assign w_push        = w_byte_done && !start;
  assign w_flush       = start && (r_state != ST_IDLE);
  assign w_strobe_take = error_strobe && !start &&
                         ((r_state == ST_COLLECT) || (r_state == ST_WAIT_CRC));

  sync_fifo_ble #(
    .AW (FIFO_AW),
    .W  (BITS_PER_BYTE)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_wr_data   (w_wr_data),
    .i_pop       (byte_ready),
    .o_rd_data   (byte_out),
    .o_not_empty (byte_valid),
    .o_count     (fill_level),
    .o_drop      (w_drop)
  );

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign rx_error = r_rx_error;
  assign overflow = r_overflow;

  // FSM, bit/byte counters, shift register and sticky status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_bits_left   <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_rx_error    <= 1'b0;
      r_overflow    <= 1'b0;
      r_crc_en_q    <= 1'b0;
      r_strobe_seen <= 1'b0;
    end else if (start) begin
      r_bits_left   <= n_bits;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_rx_error    <= 1'b0;
      r_overflow    <= 1'b0;
      r_crc_en_q    <= crc_enable;
      r_strobe_seen <= 1'b0;
      r_state       <= (n_bits == ZERO) ? ST_DONE : ST_COLLECT;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_strobe_take) begin
        r_rx_error    <= r_rx_error | error_in;
        r_strobe_seen <= 1'b1;
      end
      case (r_state)
        ST_COLLECT: begin
          if (w_bit_take) begin
            r_bits_left <= r_bits_left - ONE;
            r_bit_idx   <= r_bit_idx + 3'd1;
            r_shift     <= w_byte_done ? 8'd0 : w_wr_data;
          end
          if (w_last_bit) begin
            r_state <= (r_crc_en_q && !r_strobe_seen && !error_strobe) ? ST_WAIT_CRC : ST_DONE;
          end
        end
        ST_WAIT_CRC: begin
          if (error_strobe) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_payload_byte_packer_ble.sv
// Directed bench for the BLE payload byte packer.
module tb_rx_payload_byte_packer_ble;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] n_bits;
  logic        crc_enable;
  logic        bit_in;
  logic        bit_valid;
  logic        error_in;
  logic        error_strobe;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic [4:0]  fill_level;
  logic        busy;
  logic        done;
  logic        rx_error;
  logic        overflow;

  int total;
  int bad;

  rx_payload_byte_packer_ble #(.FIFO_AW(4), .NBITS_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .n_bits       (n_bits),
    .crc_enable   (crc_enable),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .error_in     (error_in),
    .error_strobe (error_strobe),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .fill_level   (fill_level),
    .busy         (busy),
    .done         (done),
    .rx_error     (rx_error),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive n bits of v LSB first, one per cycle, then drop bit_valid.
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in    = v[i];
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] nb, input logic crc);
    start      = 1'b1;
    n_bits     = nb;
    crc_enable = crc;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0; start = 1'b0; n_bits = '0; crc_enable = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0; error_in = 1'b0; error_strobe = 1'b0;
    byte_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", byte_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_done", done, 0);
    chk("rst_err", rx_error, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_byte", byte_out, 0);
    reset = 1'b1;
    tick();

    // 1: two full bytes, reader always ready
    byte_ready = 1'b1;
    do_start(16, 1'b0);
    chk("t1_busy", busy, 1);
    send_bits(16'h00A5, 8);
    chk("t1_b0", byte_out, 8'hA5);
    chk("t1_v0", byte_valid, 1);
    chk("t1_done_early", done, 0);
    send_bits(16'h003C, 8);
    chk("t1_b1", byte_out, 8'h3C);
    chk("t1_done", done, 1);
    chk("t1_err", rx_error, 0);
    tick();
    chk("t1_done_off", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_drained", byte_valid, 0);

    // 2: 12 bits, zero-padded second byte, reader stalled
    byte_ready = 1'b0;
    do_start(12, 1'b0);
    send_bits(16'h00FF, 8);
    chk("t2_fill1", fill_level, 1);
    chk("t2_head", byte_out, 8'hFF);
    send_bits(16'h000F, 4);
    chk("t2_fill2", fill_level, 2);
    chk("t2_done", done, 1);
    tick();
    chk("t2_idle", busy, 0);
    byte_ready = 1'b1;
    chk("t2_pop0", byte_out, 8'hFF);
    tick();
    chk("t2_pop1", byte_out, 8'h0F);
    chk("t2_fill_after", fill_level, 1);
    tick();
    chk("t2_empty", byte_valid, 0);

    // 3: 17 bytes into a 16-deep FIFO
    byte_ready = 1'b0;
    do_start(136, 1'b0);
    for (int k = 0; k < 17; k++) send_bits(16'(k + 1), 8);
    chk("t3_fill", fill_level, 16);
    chk("t3_ovf", overflow, 1);
    chk("t3_done", done, 1);
    tick();
    byte_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t3_pop%0d", k), byte_out, k + 1);
      tick();
    end
    chk("t3_empty", byte_valid, 0);
    chk("t3_ovf_sticky", overflow, 1);

    // 4: CRC wait with late error strobe
    do_start(8, 1'b1);
    chk("t4_ovf_clr", overflow, 0);
    send_bits(16'h005A, 8);
    chk("t4_byte", byte_out, 8'h5A);
    chk("t4_wait_busy", busy, 1);
    chk("t4_no_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t4_hold%0d", k), busy, 1);
      chk($sformatf("t4_nodone%0d", k), done, 0);
    end
    error_strobe = 1'b1;
    error_in     = 1'b1;
    tick();
    error_strobe = 1'b0;
    error_in     = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_err", rx_error, 1);
    tick();
    chk("t4_idle", busy, 0);
    chk("t4_err_sticky", rx_error, 1);
    // zero-length packet: done one cycle later, error cleared, no bytes
    do_start(0, 1'b0);
    chk("t5z_done", done, 1);
    chk("t5z_err_clr", rx_error, 0);
    chk("t5z_fill", fill_level, 0);
    tick();
    chk("t5z_done_off", done, 0);
    chk("t5z_idle", busy, 0);

    // 5: abort mid-packet, then a clean 8-bit packet
    byte_ready = 1'b0;
    do_start(16, 1'b0);
    send_bits(16'h00C3, 8);
    chk("t5_fill_pre", fill_level, 1);
    send_bits(16'h0015, 5);
    do_start(8, 1'b0);
    chk("t5_flushed", fill_level, 0);
    chk("t5_busy", busy, 1);
    send_bits(16'h0096, 8);
    chk("t5_fill", fill_level, 1);
    chk("t5_byte", byte_out, 8'h96);
    chk("t5_done", done, 1);
    byte_ready = 1'b1;
    tick();
    chk("t5_one_byte", byte_valid, 0);

    // 6: reset in the middle of collection
    byte_ready = 1'b0;
    do_start(64, 1'b0);
    send_bits(16'h0011, 8);
    send_bits(16'h0022, 8);
    send_bits(16'h0033, 8);
    send_bits(16'h0005, 3);
    chk("t6_fill", fill_level, 3);
    error_strobe = 1'b1;
    error_in     = 1'b1;
    tick();
    error_strobe = 1'b0;
    error_in     = 1'b0;
    chk("t6_err_set", rx_error, 1);
    reset = 1'b0;
    tick();
    chk("t6_valid", byte_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_fill0", fill_level, 0);
    chk("t6_err", rx_error, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_done", done, 0);
    send_bits(16'h00FF, 8);
    chk("t6_no_bytes", fill_level, 0);
    reset = 1'b1;
    send_bits(16'h00FF, 8);
    chk("t6_idle_ignore", fill_level, 0);
    chk("t6_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
